// File: rtl/squeeze_bias_apply.sv
// Squeeze-layer bias apply: adds the per-channel sign-magnitude bias to a stream of
// two's-complement accumulator beats, then applies optional ReLU and saturates to
// 16-bit sign-magnitude. Two-stage pipeline with valid/ready backpressure.
module squeeze_bias_apply #(
    parameter int unsigned NUM_CH  = 64,
    parameter int unsigned ACC_W   = 24,
    parameter bit          RELU_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0][15:0]     bias_mem,
    input  logic                        ch_clr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ACC_W-1:0]            acc_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [15:0]                 out_data,
    output logic [$clog2(NUM_CH)-1:0]   out_ch,
    output logic                        out_last,
    output logic                        sat_flag
);

    localparam int unsigned ChW  = $clog2(NUM_CH);
    localparam int unsigned SumW = ACC_W + 1;

    localparam logic [ChW-1:0]         LastCh = ChW'(NUM_CH - 1);
    localparam logic signed [SumW-1:0] MaxPos = SumW'(32767);
    localparam logic signed [SumW-1:0] MinNeg = -MaxPos;
    localparam logic signed [SumW-1:0] Zero   = '0;

    logic                   en;
    logic                   accept;
    logic [ChW-1:0]         cnt_q, cnt_d;
    logic [ChW-1:0]         ch_tag;
    logic [15:0]            bias_word;
    logic signed [SumW-1:0] bias_mag;
    logic signed [SumW-1:0] bias_tc;
    logic signed [SumW-1:0] acc_sext;
    logic signed [SumW-1:0] sum_d;

    logic                   s1_valid_q;
    logic signed [SumW-1:0] s1_sum_q;
    logic [ChW-1:0]         s1_ch_q;
    logic                   s1_last_q;

    logic [15:0]            res_data;
    logic                   res_sat;

    logic                   out_valid_q;
    logic [15:0]            out_data_q;
    logic [ChW-1:0]         out_ch_q;
    logic                   out_last_q;
    logic                   sat_q, sat_d;

    // Both stages move together; a full, stalled output stage freezes the whole pipe.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // Channel tag, bias lookup and the biased sum feeding stage 1.
    always_comb begin
        // A coincident ch_clr makes this beat channel 0.
        ch_tag    = ch_clr ? '0 : cnt_q;
        cnt_d     = cnt_q;
        if (accept) begin
            cnt_d = (ch_tag == LastCh) ? '0 : ch_tag + 1'b1;
        end else if (ch_clr) begin
            cnt_d = '0;
        end
        bias_word = bias_mem[ch_tag];
        bias_mag  = SumW'(bias_word[14:0]);
        // Negative zero (0x8000) falls out as 0 here.
        bias_tc   = bias_word[15] ? -bias_mag : bias_mag;
        acc_sext  = {acc_in[ACC_W-1], acc_in};
        sum_d     = acc_sext + bias_tc;
    end

    // ReLU, saturation and sign-magnitude encoding of the stage-1 sum.
    always_comb begin
        res_data = '0;
        res_sat  = 1'b0;
        if (RELU_EN && s1_sum_q <= Zero) begin
            res_data = '0;
        end else if (s1_sum_q > MaxPos) begin
            res_data = 16'h7FFF;
            res_sat  = 1'b1;
        end else if (s1_sum_q < MinNeg) begin
            // Also catches -32768, which has no sign-magnitude encoding.
            res_data = 16'hFFFF;
            res_sat  = 1'b1;
        end else if (s1_sum_q < Zero) begin
            res_data = {1'b1, 15'(-s1_sum_q)};
        end else begin
            res_data = {1'b0, s1_sum_q[14:0]};
        end
    end

    // Sticky saturation flag: a saturating stage-2 load beats a same-cycle clear.
    always_comb begin
        sat_d = sat_q;
        if (ch_clr) begin
            sat_d = 1'b0;
        end
        if (en && s1_valid_q && res_sat) begin
            sat_d = 1'b1;
        end
    end

    // Channel counter and saturation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    // Stage 1: biased sum plus channel and last tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_ch_q    <= '0;
            s1_last_q  <= 1'b0;
        end else if (en) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_sum_q  <= sum_d;
                s1_ch_q   <= ch_tag;
                s1_last_q <= (ch_tag == LastCh);
            end
        end
    end

    // Stage 2: encoded result presented on the output stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else if (en) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= res_data;
                out_ch_q   <= s1_ch_q;
                out_last_q <= s1_last_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_squeeze_bias_apply.sv
// Bench for squeeze_bias_apply: one ReLU instance and one signed instance share stimulus.
module tb_squeeze_bias_apply;

    localparam int NUM_CH = 64;
    localparam int ACC_W  = 24;

    logic clk = 1'b0;
    logic rst;
    logic [NUM_CH-1:0][15:0] bias_mem;
    logic ch_clr, in_valid, out_ready;
    logic [ACC_W-1:0] acc_in;
    logic in_ready_r1, in_ready_r0, out_valid_r1, out_valid_r0;
    logic [15:0] out_data_r1, out_data_r0;
    logic [5:0] out_ch_r1, out_ch_r0;
    logic out_last_r1, out_last_r0, sat_r1, sat_r0;

    always #5 clk = ~clk;

    squeeze_bias_apply #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .RELU_EN(1'b1)) u_relu (
        .clk(clk), .rst(rst), .bias_mem(bias_mem), .ch_clr(ch_clr),
        .in_valid(in_valid), .in_ready(in_ready_r1), .acc_in(acc_in),
        .out_valid(out_valid_r1), .out_ready(out_ready), .out_data(out_data_r1),
        .out_ch(out_ch_r1), .out_last(out_last_r1), .sat_flag(sat_r1)
    );

    squeeze_bias_apply #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .RELU_EN(1'b0)) u_signed (
        .clk(clk), .rst(rst), .bias_mem(bias_mem), .ch_clr(ch_clr),
        .in_valid(in_valid), .in_ready(in_ready_r0), .acc_in(acc_in),
        .out_valid(out_valid_r0), .out_ready(out_ready), .out_data(out_data_r0),
        .out_ch(out_ch_r0), .out_last(out_last_r0), .sat_flag(sat_r0)
    );

    typedef struct {
        bit          clr;
        int          ch;
        int          acc;
        logic [15:0] d1;
        logic [15:0] d0;
        bit          s1;
        bit          s0;
    } vec_t;

    typedef struct {
        logic [15:0] d1;
        logic [15:0] d0;
        int          ch;
    } exp_t;

    int n_vec = 0;
    int n_err = 0;
    int cnt   = 0;
    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {sat, data} for a beat on channel ch.
    function automatic logic [16:0] ref_beat(input int acc, input int ch, input bit relu);
        logic [15:0] w;
        int b, s;
        w = bias_mem[ch];
        b = w[15] ? -int'(w[14:0]) : int'(w[14:0]);
        s = acc + b;
        if (relu && s <= 0) return {1'b0, 16'h0000};
        if (s > 32767)      return {1'b1, 16'h7FFF};
        if (s < -32767)     return {1'b1, 16'hFFFF};
        if (s < 0)          return {1'b0, 1'b1, 15'(-s)};
        return {1'b0, 1'b0, 15'(s)};
    endfunction

    // Entered and left at a negedge with the pipeline idle.
    task automatic do_clr();
        ch_clr   = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        ch_clr = 1'b0;
        cnt    = 0;
    endtask

    task automatic run_stream(input int nbeats, input bit rnd, input int burst_at);
        exp_t sb[$];
        exp_t e;
        logic [16:0] r;
        int sent = 0, got = 0, cyc = 0, bubbles = 0, a;
        bit started = 0;
        while (got < nbeats && cyc < nbeats * 4 + 100) begin
            out_ready = rnd ? (($urandom_range(0, 9) >= 3) &&
                               !(cyc >= burst_at && cyc < burst_at + 5)) : 1'b1;
            a = int'($urandom_range(0, 80000)) - 40000;
            in_valid = (sent < nbeats);
            acc_in   = ACC_W'(a);
            #1;
            check("in_ready", in_ready_r1, !(out_valid_r1 && !out_ready));
            if (out_valid_r1 && out_ready) begin
                if (sb.size() == 0) begin
                    check("stream_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("stream_d_relu", out_data_r1, e.d1);
                    check("stream_d_signed", out_data_r0, e.d0);
                    check("stream_ch", out_ch_r1, e.ch);
                    check("stream_last", out_last_r1, e.ch == NUM_CH - 1);
                end
                got++;
            end else if (!rnd && started && !out_valid_r1) begin
                bubbles++;
            end
            if (out_valid_r1) started = 1;
            if (in_valid && in_ready_r1) begin
                r = ref_beat(a, cnt, 1'b1);
                e.d1 = r[15:0];
                r = ref_beat(a, cnt, 1'b0);
                e.d0 = r[15:0];
                e.ch = cnt;
                sb.push_back(e);
                cnt = (cnt + 1) % NUM_CH;
                sent++;
            end
            cyc++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", got, nbeats);
        if (!rnd) check("stream_bubbles", bubbles, 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            bias_mem[i] = 16'((i * 97) & 16'h3FFF) | ((i % 3 == 0) ? 16'h8000 : 16'h0000);
        end
        bias_mem[0]  = 16'h805E;
        bias_mem[1]  = 16'h8000;
        bias_mem[2]  = 16'h001A;
        bias_mem[3]  = 16'h0000;
        bias_mem[37] = 16'h02A6;
        bias_mem[40] = 16'h0064;
        bias_mem[63] = 16'h7FFF;

        //        clr   ch   acc      relu      signed    s1  s0
        vt[0]  = '{1'b1, 0,  100,    16'h0006, 16'h0006, 0, 0};
        vt[1]  = '{1'b1, 0,  50,     16'h0000, 16'h802C, 0, 0};
        vt[2]  = '{1'b0, 1,  0,      16'h0000, 16'h0000, 0, 0};
        vt[3]  = '{1'b0, 2,  40000,  16'h7FFF, 16'h7FFF, 1, 1};
        vt[4]  = '{1'b1, 0,  -40000, 16'h0000, 16'hFFFF, 0, 1};
        vt[5]  = '{1'b0, 1,  -32768, 16'h0000, 16'hFFFF, 0, 1};
        vt[6]  = '{1'b0, 2,  32741,  16'h7FFF, 16'h7FFF, 0, 1};
        vt[7]  = '{1'b1, 0,  -32673, 16'h0000, 16'hFFFF, 0, 0};
        vt[8]  = '{1'b0, 1,  32768,  16'h7FFF, 16'h7FFF, 1, 1};
        vt[9]  = '{1'b1, 37, 0,      16'h02A6, 16'h02A6, 0, 0};
        vt[10] = '{1'b0, 40, -200,   16'h0000, 16'h8064, 0, 0};
        vt[11] = '{1'b0, 63, 1,      16'h7FFF, 16'h7FFF, 1, 1};
        vt[12] = '{1'b0, 3,  -5,     16'h0000, 16'h8005, 1, 1};

        rst = 1'b1; ch_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; acc_in = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", out_valid_r1, 0);
        check("rst_data", out_data_r1, 0);
        check("rst_ch", out_ch_r1, 0);
        check("rst_last", out_last_r1, 0);
        check("rst_sat", sat_r1, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed single beats, each checked exactly two cycles after acceptance.
        for (int v = 0; v < 13; v++) begin
            int fill = 0;
            if (vt[v].clr) do_clr();
            while (cnt != vt[v].ch) begin
                in_valid = 1'b1;
                acc_in   = '0;
                @(negedge clk);
                cnt = (cnt + 1) % NUM_CH;
                fill++;
            end
            in_valid = 1'b1;
            acc_in   = ACC_W'(vt[v].acc);
            @(negedge clk);
            cnt = (cnt + 1) % NUM_CH;
            in_valid = 1'b0;
            if (fill == 0) check("vec_early_valid", out_valid_r1, 0);
            @(negedge clk);
            check("vec_valid", out_valid_r1, 1);
            check("vec_d_relu", out_data_r1, vt[v].d1);
            check("vec_d_signed", out_data_r0, vt[v].d0);
            check("vec_ch", out_ch_r1, vt[v].ch);
            check("vec_last", out_last_r1, vt[v].ch == NUM_CH - 1);
            check("vec_sat_relu", sat_r1, vt[v].s1);
            check("vec_sat_signed", sat_r0, vt[v].s0);
        end
        @(negedge clk);

        // 130 back-to-back beats, then the same under random backpressure.
        do_clr();
        run_stream(130, 1'b0, 1000);
        do_clr();
        run_stream(200, 1'b1, 50);

        // ch_clr coincident with an accept: that beat is ch0, the next is ch1.
        do_clr();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            acc_in   = '0;
            @(negedge clk);
        end
        ch_clr = 1'b1;
        acc_in = ACC_W'(100);
        @(negedge clk);
        ch_clr = 1'b0;
        acc_in = '0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("clracc_ch0", out_ch_r1, 0);
        check("clracc_d0", out_data_r1, 16'h0006);
        @(negedge clk);
        check("clracc_ch1", out_ch_r1, 1);
        check("clracc_d1", out_data_r1, 16'h0000);
        @(negedge clk);

        // Saturating stage-2 load coincident with ch_clr: set wins; a later clear clears.
        do_clr();
        in_valid = 1'b1;
        acc_in = '0;
        @(negedge clk);
        @(negedge clk);
        acc_in = ACC_W'(40000);
        @(negedge clk);
        in_valid = 1'b0;
        ch_clr   = 1'b1;
        @(negedge clk);
        check("satwin_flag", sat_r1, 1);
        check("satwin_data", out_data_r1, 16'h7FFF);
        @(negedge clk);
        ch_clr = 1'b0;
        check("satclr_flag", sat_r1, 0);
        @(negedge clk);

        // Reset with two beats in flight.
        do_clr();
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            acc_in   = (k == 2) ? ACC_W'(40000) : ACC_W'(100 + k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("prerst_valid", out_valid_r1, 1);
        check("prerst_sat", sat_r1, 1);
        rst = 1'b1;
        #1;
        check("midrst_valid", out_valid_r1, 0);
        check("midrst_data", out_data_r1, 0);
        check("midrst_ch", out_ch_r1, 0);
        check("midrst_last", out_last_r1, 0);
        check("midrst_sat", sat_r1, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("postrst_no_stale", out_valid_r1, 0);
        end
        in_valid = 1'b1;
        acc_in   = ACC_W'(100);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("postrst_valid", out_valid_r1, 1);
        check("postrst_ch", out_ch_r1, 0);
        check("postrst_data", out_data_r1, 16'h0006);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
